// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller.
// Divides clk into a count tick, ripples that tick through a chain of BCD
// digit counters as per-digit enables, and issues the counters' clear pulse,
// the lap display-hold flag and a sticky overflow flag.
//
// Button interface: btn_start_stop and btn_lap_clear are single-cycle pulses,
// already debounced and synchronised. Each high cycle is one press, consumed
// on the next rising clk edge; no acknowledge is returned. Outputs depend on
// buttons only through registers.
module stopwatch_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int NDIG    = 4,
    localparam int DIV_W  = $clog2(CLK_DIV)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_start_stop,
    input  logic              btn_lap_clear,
    input  logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   cnt_enable,
    output logic              cnt_reset,
    output logic              display_hold,
    output logic              overflow,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic             clear_act;
    logic [DIV_W-1:0] prescaler;
    logic             running;
    logic             tick;
    logic             all_nines;

    assign state = state_q;

    // State register; display_hold is registered alongside so it tracks LAP exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            display_hold <= 1'b0;
        end else begin
            state_q      <= state_d;
            display_hold <= (state_d == LAP);
        end
    end

    // Next-state logic; start_stop has priority over lap_clear when both pulse.
    always_comb begin
        state_d   = state_q;
        clear_act = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_start_stop) begin
                    state_d = RUN;
                end else if (btn_lap_clear) begin
                    clear_act = 1'b1;
                end
            end
            RUN: begin
                if (btn_start_stop) begin
                    state_d = PAUSE;
                end else if (btn_lap_clear) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (btn_start_stop) begin
                    state_d = PAUSE;
                end else if (btn_lap_clear) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (btn_start_stop) begin
                    state_d = RUN;
                end else if (btn_lap_clear) begin
                    state_d   = IDLE;
                    clear_act = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: count tick and ripple-carry enables, suppressed during counter clear.
    always_comb begin
        logic carry;
        running    = (state_q == RUN) || (state_q == LAP);
        tick       = running && (prescaler == PRESC_MAX);
        cnt_enable = '0;
        carry      = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            cnt_enable[i] = tick && carry && !cnt_reset;
            carry         = carry && (digits[4*i +: 4] == 4'd9);
        end
        all_nines = carry;
    end

    // Prescaler, counter clear pulse and sticky overflow.
    // The prescaler holds while paused/idle so a resume keeps sub-tick phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            cnt_reset <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            cnt_reset <= clear_act;
            if (clear_act) begin
                prescaler <= '0;
                overflow  <= 1'b0;
            end else begin
                if (running) begin
                    if (prescaler == PRESC_MAX) begin
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                if (tick && all_nines) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4, NDIG=2.
// A behavioural two-digit BCD counter chain closes the loop on digits.
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

    localparam int CLK_DIV = 4;
    localparam int NDIG    = 2;

    logic            clk;
    logic            reset_n;
    logic            btn_start_stop;
    logic            btn_lap_clear;
    logic [7:0]      digits;
    logic [NDIG-1:0] cnt_enable;
    logic            cnt_reset;
    logic            display_hold;
    logic            overflow;
    logic [1:0]      state;

    logic [7:0]      dig_q = 8'h00;
    logic            preload = 1'b0;
    logic [7:0]      preload_val = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    stopwatch_ctrl #(
        .CLK_DIV(CLK_DIV),
        .NDIG(NDIG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_start_stop(btn_start_stop),
        .btn_lap_clear(btn_lap_clear),
        .digits(digits),
        .cnt_enable(cnt_enable),
        .cnt_reset(cnt_reset),
        .display_hold(display_hold),
        .overflow(overflow),
        .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit counter chain model: sync clear, optional preload, mod-10 digits.
    always @(posedge clk) begin
        if (cnt_reset) begin
            dig_q <= 8'h00;
        end else if (preload) begin
            dig_q <= preload_val;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (cnt_enable[i]) begin
                    dig_q[4*i +: 4] <= (dig_q[4*i +: 4] == 4'd9) ? 4'd0 : dig_q[4*i +: 4] + 4'd1;
                end
            end
        end
    end
    assign digits = dig_q;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse starting at the current falling edge; returns one cycle later.
    task automatic press(input logic ss, input logic lc);
        btn_start_stop = ss;
        btn_lap_clear  = lc;
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [NDIG-1:0] en_or;
        int ticks0;
        int ticks1;
        int phase_err;
        int carry_err;

        reset_n        = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;

        // Reset values
        @(negedge clk);
        check_eq("rst_state", 16'(state), 16'h0);
        check_eq("rst_cnt_reset", 16'(cnt_reset), 16'h1);
        check_eq("rst_overflow", 16'(overflow), 16'h0);
        check_eq("rst_hold", 16'(display_hold), 16'h0);
        check_eq("rst_enable", 16'(cnt_enable), 16'h0);

        // Release: cnt_reset holds through the first edge, then drops
        reset_n = 1'b1;
        check_eq("rel_cnt_reset_hi", 16'(cnt_reset), 16'h1);
        @(negedge clk);
        check_eq("rel_cnt_reset_lo", 16'(cnt_reset), 16'h0);
        en_or = '0;
        for (int i = 0; i < 20; i++) begin
            en_or |= cnt_enable;
            @(negedge clk);
        end
        check_eq("idle_no_enable", 16'(en_or), 16'h0);
        check_eq("idle_state", 16'(state), 16'h0);

        // Lap/clear in IDLE: one-cycle clear, stay IDLE
        press(1'b0, 1'b1);
        check_eq("idle_clear_pulse", 16'(cnt_reset), 16'h1);
        check_eq("idle_clear_state", 16'(state), 16'h0);
        @(negedge clk);
        check_eq("idle_clear_end", 16'(cnt_reset), 16'h0);

        // Start and run 40 cycles: prescaler phase k%4, tick at phase 3
        for (int v = 1; v <= 10; v++) exp_q.push_back(8'((v / 10) * 16 + (v % 10)));
        press(1'b1, 1'b0);
        check_eq("run_state", 16'(state), 16'h1);
        ticks0 = 0; ticks1 = 0; phase_err = 0; carry_err = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0 && (k % 4) == 0) check_eq("run_digits", 16'(digits), 16'(exp_q.pop_front()));
            if (cnt_enable[0] != ((k % 4) == 3)) phase_err++;
            if (cnt_enable[1] && digits[3:0] != 4'd9) carry_err++;
            ticks0 += int'(cnt_enable[0]);
            ticks1 += int'(cnt_enable[1]);
            @(negedge clk);
        end
        check_eq("run_tick_phase", 16'(phase_err), 16'h0);
        check_eq("run_carry_cond", 16'(carry_err), 16'h0);
        check_eq("run_ticks0", 16'(ticks0), 16'd10);
        check_eq("run_ticks1", 16'(ticks1), 16'd1);
        check_eq("run_digits_10", 16'(digits), 16'h10);

        // Pause with prescaler at 2, wait, resume: tick on the second cycle
        step(1);
        press(1'b1, 1'b0);
        check_eq("pause_state", 16'(state), 16'h2);
        en_or = '0;
        for (int i = 0; i < 50; i++) begin
            en_or |= cnt_enable;
            @(negedge clk);
        end
        check_eq("pause_no_enable", 16'(en_or), 16'h0);
        check_eq("pause_digits", 16'(digits), 16'h10);
        press(1'b1, 1'b0);
        check_eq("resume_state", 16'(state), 16'h1);
        check_eq("resume_first", 16'(cnt_enable), 16'h0);
        @(negedge clk);
        check_eq("resume_tick", 16'(cnt_enable), 16'h1);

        // Lap pressed on a tick edge: tick still counts, LAP entered
        press(1'b0, 1'b1);
        check_eq("lap_state", 16'(state), 16'h3);
        check_eq("lap_hold", 16'(display_hold), 16'h1);
        check_eq("lap_digits", 16'(digits), 16'h11);
        step(3);
        check_eq("lap_tick", 16'(cnt_enable), 16'h1);
        press(1'b0, 1'b1);
        check_eq("unlap_state", 16'(state), 16'h1);
        check_eq("unlap_hold", 16'(display_hold), 16'h0);
        check_eq("unlap_digits", 16'(digits), 16'h12);

        // Preload 99, full-chain wrap sets overflow
        preload_val = 8'h99;
        preload     = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        step(2);
        check_eq("ovf_enable", 16'(cnt_enable), 16'h3);
        check_eq("ovf_before", 16'(overflow), 16'h0);
        @(negedge clk);
        check_eq("ovf_set", 16'(overflow), 16'h1);
        check_eq("ovf_wrap", 16'(digits), 16'h00);
        press(1'b1, 1'b0);
        check_eq("ovf_pause", 16'(state), 16'h2);
        check_eq("ovf_sticky", 16'(overflow), 16'h1);
        press(1'b0, 1'b1);
        check_eq("clr_pulse", 16'(cnt_reset), 16'h1);
        check_eq("clr_overflow", 16'(overflow), 16'h0);
        check_eq("clr_state", 16'(state), 16'h0);
        check_eq("clr_enable", 16'(cnt_enable), 16'h0);
        @(negedge clk);
        check_eq("clr_pulse_end", 16'(cnt_reset), 16'h0);

        // Both buttons together in RUN: start_stop wins
        press(1'b1, 1'b0);
        step(1);
        press(1'b1, 1'b1);
        check_eq("both_state", 16'(state), 16'h2);
        check_eq("both_hold", 16'(display_hold), 16'h0);

        // Async reset mid-RUN
        press(1'b1, 1'b0);
        step(2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_state", 16'(state), 16'h0);
        check_eq("async_cnt_reset", 16'(cnt_reset), 16'h1);
        check_eq("async_enable", 16'(cnt_enable), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("async_rel", 16'(cnt_reset), 16'h0);
        check_eq("async_digits", 16'(digits), 16'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
